// File: rtl/direction_toggle_pkg.sv
// Shared types and constants for the counter control path.
// The FSM state type and the direction encoding are also used by the
// counter-side select mux, so they live here rather than in the top.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } dbnc_state_t;

  // Direction bit meaning as seen by the counter's select input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Debounce counter width; it has to hold values up to DEBOUNCE_CYCLES-1.
  function automatic int dbnc_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/direction_toggle_if.sv
// Button-in / direction-out bundle between the panel logic and the toggle.
// The toggled pulse only exists when DIR_TOGGLE_PULSE_EN is defined.
interface direction_toggle_if;

  logic button;
  logic select;
  logic button_level;
`ifdef DIR_TOGGLE_PULSE_EN
  logic toggled;
`endif

  // Side that owns the raw button and consumes the direction.
  modport master (
    output button,
    input  select,
    input  button_level
`ifdef DIR_TOGGLE_PULSE_EN
   ,input  toggled
`endif
  );

  // The direction_toggle block itself.
  modport slave (
    input  button,
    output select,
    output button_level
`ifdef DIR_TOGGLE_PULSE_EN
   ,output toggled
`endif
  );

endinterface

// File: rtl/direction_toggle_sync.sv
// Generic multi-flop synchroniser for a single asynchronous input bit.
// All stages clear to 0; q is the last stage.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/direction_toggle.sv
// Push-button direction toggle: synchronise, debounce, flip the direction
// bit once per accepted press. Releases only update button_level.
// Optional feature macro: DIR_TOGGLE_PULSE_EN adds the toggled pulse output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE_LOW  | debounced level 0, waiting for sync_btn to go high
// WAIT_HIGH | sync_btn high, counting toward an accepted press
// IDLE_HIGH | debounced level 1, waiting for sync_btn to go low
// WAIT_LOW  | sync_btn low, counting toward an accepted release
module direction_toggle
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2
) (
  input logic              clk,
  input logic              clear,
  direction_toggle_if.slave bus
);

  localparam int            CW       = dbnc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_btn;
  dbnc_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          select_q, select_d;
  logic          level_q, level_d;
`ifdef DIR_TOGGLE_PULSE_EN
  logic          toggled_q, toggled_d;
`endif

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk   (clk),
    .clear (clear),
    .d     (bus.button),
    .q     (sync_btn)
  );

  // Debounce FSM: next state, counter and output updates.
  // The counter is zeroed on every WAIT entry, so it never needs to wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    level_d  = level_q;
`ifdef DIR_TOGGLE_PULSE_EN
    toggled_d = 1'b0;
`endif
    case (state_q)
      IDLE_LOW: begin
        if (sync_btn) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_btn) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE_HIGH;
          level_d  = 1'b1;
          select_d = ~select_q;
`ifdef DIR_TOGGLE_PULSE_EN
          toggled_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_btn) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_btn) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; clear forces everything idle.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE_LOW;
      cnt_q    <= '0;
      select_q <= DIR_UP;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      level_q  <= level_d;
    end
  end

`ifdef DIR_TOGGLE_PULSE_EN
  // One-cycle pulse registered alongside the select flip.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) toggled_q <= 1'b0;
    else       toggled_q <= toggled_d;
  end

  assign bus.toggled = toggled_q;
`endif

  assign bus.select       = select_q;
  assign bus.button_level = level_q;

endmodule

// File: doc/direction_toggle.md
# direction_toggle

- Upstream control stage for the up/down counter.
- Takes a raw, bouncy, asynchronous push-button and synchronises and debounces it.
- Flips a registered direction bit on each qualified press.
- That bit drives the counter's `select`: 0 selects the up count, 1 selects the down count.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000: clock cycles the synchronised button must stay stable before a level change is accepted. Legal range ≥1.
- `SYNC_STAGES`, default 2: flip-flops in the input synchroniser. Legal range ≥2.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `clear`, input, 1: reset, asynchronous and active-high.
- `button`, input, 1: raw push-button, asynchronous to `clk`. 1 = pressed.
- `select`, output, 1: registered direction bit, 0 = up, 1 = down. Reset value 0.
- `button_level`, output, 1: registered debounced button level. Reset value 0.
- `toggled`, output, 1: one-cycle pulse when `select` changes. Reset value 0. Present only with `DIR_TOGGLE_PULSE_EN` (see Configuration).

## Operation

- **Synchroniser:** `button` passes through a `SYNC_STAGES`-deep flop chain; all flops reset to 0. The last stage, `sync_btn`, is the only form of `button` the FSM sees.
- **Counter:** debounce counter, width `$clog2(DEBOUNCE_CYCLES+1)`. Resets to 0. Never wraps: it is reloaded to 0 on every entry into a WAIT state.
- **FSM states:** IDLE_LOW (reset state), WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- **IDLE_LOW:**
  - `sync_btn`=1 → WAIT_HIGH, cnt←0.
  - Otherwise stay.
- **WAIT_HIGH:**
  - `sync_btn`=0 → IDLE_LOW. Bounce rejected, no output change.
  - `sync_btn`=1 and cnt==DEBOUNCE_CYCLES-1 → IDLE_HIGH. `button_level`←1, `select`←~`select`, `toggled`←1.
  - Otherwise cnt←cnt+1.
- **IDLE_HIGH:**
  - `sync_btn`=0 → WAIT_LOW, cnt←0.
  - Otherwise stay.
- **WAIT_LOW:**
  - `sync_btn`=1 → IDLE_HIGH. No change.
  - `sync_btn`=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE_LOW. `button_level`←0. `select` unchanged.
  - Otherwise cnt←cnt+1.
- **Release:** never toggles `select`. Exactly one toggle per accepted press.
- **`toggled`:** high for exactly one cycle, registered, coincident with the `select` change.
- **Bounce:** any glitch inside a WAIT state restarts qualification from the idle state. The full `DEBOUNCE_CYCLES` window is required again.
- **Clear:**
  - Asserting `clear` at any time, including mid-WAIT, immediately drives all flops, the counter, `select`, `button_level` and `toggled` to 0, and puts the FSM in IDLE_LOW.
  - A button held through `clear` deassertion is treated as a fresh press and toggles after full latency.

## Timing

- **Press latency:** `button` first sampled high at rising edge k and held stable → `select`, `button_level` and `toggled` change at edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
- **Release latency:** `button_level` falls at edge k+SYNC_STAGES+DEBOUNCE_CYCLES after the first low sample, with the same formula.
- **Minimum stable time:** a pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- **Outputs:** all outputs come from flops; no combinational path from `button` to any output.
- **Press rate:** at most one toggle per 2×DEBOUNCE_CYCLES cycles.

## Configuration

- Macro: `DIR_TOGGLE_PULSE_EN`.
- **Defined:** the `toggled` port and its flop exist, behaving as above.
- **Undefined:** the port and flop are removed.
- `select` and `button_level` behaviour and timing are identical either way.

## Structure

- **Package `counter_ctrl_pkg`:**
  - `typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} dbnc_state_t`.
  - `localparam` constants `DIR_UP`=1'b0 and `DIR_DOWN`=1'b1, shared with the counter-side mux select meaning.
- **Sub-module `bit_synchronizer`:**
  - Parameter `STAGES`; ports `clk`, `clear`, `d`, `q`.
  - Instantiated once for `button`. Reusable for other async inputs.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.

1. **Reset:** `clear`=1 with `button`=1 → `select`=0, `button_level`=0, `toggled`=0 immediately and while held.
2. **Clean press:** `button` 0→1 first sampled at edge 10 and held → `select` 0→1 and `button_level`→1 at edge 16. `toggled`=1 only in the cycle after edge 16. Release first sampled at edge 30 → `button_level`→0 at edge 36, `select` stays 1.
3. **Bounce:** `button` high for 3 cycles, low for 1, then high and stable from edge 20 → exactly one toggle, at edge 26.
4. **Two clean presses** separated by a full release → `select` goes 0→1→0, with two `toggled` pulses.
5. **Clear mid-WAIT_HIGH:** `clear` pulsed at cnt=2 with `button` held → no toggle, `select`=0. After `clear` deasserts, first sample at edge m → toggle at edge m+6.
6. **`DIR_TOGGLE_PULSE_EN` undefined:** rerun scenario 2 → `select`/`button_level` waveforms identical, `toggled` port absent.
